// File: rtl/rr_arb_mux_pkg.sv
// rr_mux_pkg: shared mode encodings, default parameters and pointer wrap helper
package rr_mux_pkg;
  localparam logic MODE_RR = 1'b0;
  localparam logic MODE_FIXED = 1'b1;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CHANNELS = 4;
  function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction
endpackage

// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: producer/consumer bundle; master drives inputs, slave is the mux
interface rr_arb_mux_if import rr_mux_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
);
  localparam int SELW = $clog2(CHANNELS);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0] in_valid;
  logic [CHANNELS-1:0] in_last;
  logic [CHANNELS-1:0] in_ready;
  logic mode;
  logic [WIDTH-1:0] out_data;
  logic [SELW-1:0] out_sel;
  logic out_valid;
  logic out_ready;
  modport master (
    output in_data, in_valid, in_last, mode, out_ready,
    input in_ready, out_data, out_sel, out_valid
  );
  modport slave (
    input in_data, in_valid, in_last, mode, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/rr_arb_mux_arbiter.sv
// rr_arbiter: combinational round-robin / fixed-priority grant with one-hot and encoded outputs
module rr_arbiter import rr_mux_pkg::*; #(
  parameter int CHANNELS = DEF_CHANNELS,
  localparam int SELW = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SELW-1:0]     ptr,
  input  logic                mode,
  output logic [CHANNELS-1:0] gnt,
  output logic [SELW-1:0]     idx,
  output logic                any_gnt
);
  function automatic logic [SELW-1:0] scan_ch(input int i, input logic [SELW-1:0] p, input logic m);
    int s = int'(p) + i;
    return SELW'((m == MODE_FIXED) ? i : (s >= CHANNELS ? s - CHANNELS : s));
  endfunction
  // scan backwards so the earliest channel in scan order is the last one written
  always_comb begin
    idx = '0;
    any_gnt = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (req[scan_ch(i, ptr, mode)]) begin
        idx = scan_ch(i, ptr, mode);
        any_gnt = 1'b1;
      end
    end
  end
  assign gnt = {{(CHANNELS-1){1'b0}}, any_gnt} << idx;
endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: arbitrated N-channel mux into a one-entry output register
// RRMUX_HOLD_EN: lock the grant to one channel until its in_last beat
module rr_arb_mux import rr_mux_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  localparam int SELW = $clog2(CHANNELS)
) (
  input logic clk,
  input logic rst_n,
  rr_arb_mux_if.slave bus
);
  logic [SELW-1:0] ptr_q, ptr_d, out_sel_q, out_sel_d, g_idx;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, any_gnt, xfer;
  logic [CHANNELS-1:0] req, gnt;
`ifdef RRMUX_HOLD_EN
  logic lock_q, lock_d;
  logic [SELW-1:0] lock_ch_q, lock_ch_d;
  assign req = lock_q ? bus.in_valid & (CHANNELS'(1) << lock_ch_q) : bus.in_valid;
`else
  logic unused_last;
  assign unused_last = ^bus.in_last;
  assign req = bus.in_valid;
`endif
  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .req(req),
    .ptr(ptr_q),
    .mode(bus.mode),
    .gnt(gnt),
    .idx(g_idx),
    .any_gnt(any_gnt)
  );
  // rst_n gates ready so no producer sees a handshake while held in reset
  assign xfer = any_gnt && (!out_valid_q || bus.out_ready) && rst_n;
  assign bus.in_ready = xfer ? gnt : '0;
  assign bus.out_data = out_data_q;
  assign bus.out_sel = out_sel_q;
  assign bus.out_valid = out_valid_q;
  always_comb begin
    out_valid_d = xfer || (out_valid_q && !bus.out_ready);
    out_data_d = xfer ? bus.in_data[g_idx*WIDTH +: WIDTH] : out_data_q;
    out_sel_d = xfer ? g_idx : out_sel_q;
    ptr_d = (xfer && bus.mode == MODE_RR) ? SELW'(ptr_inc(32'(g_idx), CHANNELS)) : ptr_q;
`ifdef RRMUX_HOLD_EN
    lock_d = xfer ? !bus.in_last[g_idx] : lock_q;
    lock_ch_d = xfer ? g_idx : lock_ch_q;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      out_sel_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
`ifdef RRMUX_HOLD_EN
      lock_q <= 1'b0;
      lock_ch_q <= '0;
`endif
    end else begin
      ptr_q <= ptr_d;
      out_sel_q <= out_sel_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef RRMUX_HOLD_EN
      lock_q <= lock_d;
      lock_ch_q <= lock_ch_d;
`endif
    end
  end
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed and random checks of rr_arb_mux against a transfer-level model
module tb_rr_arb_mux;
  import rr_mux_pkg::*;
  localparam int W = 8;
  localparam int C = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  rr_arb_mux_if #(.WIDTH(W), .CHANNELS(C)) bus();
  rr_arb_mux #(.WIDTH(W), .CHANNELS(C)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  logic pend[C];
  logic [W-1:0] pdata[C];
  logic plast[C];
  logic [C-1:0] refill;
  bit rand_en;
  logic mode_tb, ordy;
  int m_ptr, m_sel, m_lock_ch;
  logic m_valid, m_lock;
  logic [W-1:0] m_data;
  int sb[$];
  logic [C-1:0] obs_rdy;
  logic [W-1:0] obs_data, hd;
  logic [31:0] obs_sel, hs;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int model_grant();
    if (m_lock) return pend[m_lock_ch] ? m_lock_ch : -1;
    for (int k = 0; k < C; k++) begin
      int ch = mode_tb ? k : (m_ptr + k) % C;
      if (pend[ch]) return ch;
    end
    return -1;
  endfunction
  task automatic apply();
    for (int c = 0; c < C; c++) begin
      bus.in_valid[c] = pend[c];
      bus.in_last[c] = plast[c];
      bus.in_data[c*W +: W] = pdata[c];
    end
    bus.mode = mode_tb;
    bus.out_ready = ordy;
  endtask
  task automatic model_reset();
    m_ptr = 0; m_sel = 0; m_valid = 1'b0; m_data = '0; m_lock = 1'b0; m_lock_ch = 0;
    sb.delete();
  endtask
  task automatic cycle();
    int g;
    logic can;
    logic [C-1:0] er;
    @(negedge clk);
    g = model_grant();
    can = !m_valid || ordy;
    er = (rst_n && g >= 0 && can) ? C'(1) << g : '0;
    obs_rdy = bus.in_ready;
    obs_data = bus.out_data;
    obs_sel = 32'(bus.out_sel);
    check("in_ready", 32'(bus.in_ready), 32'(er));
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("out_data", 32'(bus.out_data), 32'(m_data));
    check("out_sel", 32'(bus.out_sel), m_sel);
    if (rst_n && bus.out_valid && ordy)
      check("sb_pop", 32'({bus.out_sel, bus.out_data}), sb.size() != 0 ? sb.pop_front() : 32'hFFFF_FFFF);
    @(posedge clk);
    if (rst_n) begin
      if (g >= 0 && can) begin
        m_data = pdata[g]; m_sel = g; m_valid = 1'b1;
        sb.push_back(g * 256 + int'(pdata[g]));
        if (!mode_tb) m_ptr = (g + 1) % C;
`ifdef RRMUX_HOLD_EN
        m_lock = !plast[g]; m_lock_ch = g;
`endif
        pend[g] = 1'b0;
      end else if (ordy) m_valid = 1'b0;
    end
    #1;
    for (int c = 0; c < C; c++)
      if (!pend[c] && (refill[c] || (rand_en && $urandom_range(2) == 0))) begin
        pend[c] = 1'b1;
        pdata[c] = W'($urandom);
        plast[c] = rand_en ? 1'($urandom_range(1)) : 1'b1;
      end
    if (rand_en) begin
      ordy = $urandom_range(9) < 7;
      if ($urandom_range(15) == 0) mode_tb = ~mode_tb;
    end
    apply();
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int c = 0; c < C; c++) begin pend[c] = 1'b1; pdata[c] = W'(c + 1); plast[c] = 1'b1; end
    refill = '1; rand_en = 0; mode_tb = MODE_RR; ordy = 1'b1;
    model_reset(); apply();
    repeat (2) begin cycle(); check("rst_rdy", 32'(obs_rdy), 32'h0); end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("rr_seq", 32'(obs_rdy), 32'(1 << (k % C)));
      if (k > 0) check("rr_sel", obs_sel, 32'(k - 1));
    end
    mode_tb = MODE_FIXED; refill = 4'b1010; pend[0] = 1'b0; pend[2] = 1'b0; apply();
    repeat (4) begin cycle(); check("fix_ch1", 32'(obs_rdy), 32'h2); end
    mode_tb = MODE_RR; apply();
    repeat (3) cycle();
    refill = '0;
    for (int c = 0; c < C; c++) pend[c] = 1'b0;
    apply();
    repeat (2) cycle();
    pend[3] = 1'b1; pdata[3] = 8'hA5; apply();
    cycle();
    pend[0] = 1'b1; pend[2] = 1'b1; pdata[0] = 8'h11; pdata[2] = 8'h22; apply();
    cycle();
    check("a5_data", 32'(obs_data), 32'hA5);
    check("a5_sel", obs_sel, 32'd3);
    check("wrap_ch0", 32'(obs_rdy), 32'h1);
    refill = '1;
    for (int c = 0; c < C; c++) if (!pend[c]) begin pend[c] = 1'b1; pdata[c] = W'($urandom); end
    apply();
    cycle();
    ordy = 1'b0; apply();
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_rdy", 32'(obs_rdy), 32'h0);
      if (k == 0) begin hd = obs_data; hs = obs_sel; end
      else begin check("bp_data", 32'(obs_data), 32'(hd)); check("bp_sel", obs_sel, hs); end
    end
    ordy = 1'b1; apply();
    repeat (6) cycle();
    ordy = 1'b0; apply();
    cycle();
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'h0);
    check("arst_rdy", 32'(bus.in_ready), 32'h0);
    model_reset();
    refill = '0;
    for (int c = 0; c < C; c++) pend[c] = 1'b0;
    ordy = 1'b1; apply();
    @(posedge clk);
    #1 rst_n = 1'b1;
`ifdef RRMUX_HOLD_EN
    pend[1] = 1'b1; plast[1] = 1'b0; pdata[1] = 8'h31;
    pend[2] = 1'b1; plast[2] = 1'b1; pdata[2] = 8'h42;
    apply(); cycle(); check("lk_b1", 32'(obs_rdy), 32'h2);
    pend[1] = 1'b1; plast[1] = 1'b0; pdata[1] = 8'h32;
    apply(); cycle(); check("lk_b2", 32'(obs_rdy), 32'h2);
    apply(); cycle(); check("lk_gap", 32'(obs_rdy), 32'h0);
    pend[1] = 1'b1; plast[1] = 1'b1; pdata[1] = 8'h33;
    apply(); cycle(); check("lk_b3", 32'(obs_rdy), 32'h2);
    apply(); cycle(); check("lk_next", 32'(obs_rdy), 32'h4);
`endif
    rand_en = 1;
    repeat (3000) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
